// File: rtl/bubble_pkg.sv
// Shared defaults, FSM state encoding and launch-direction constants for the
// bubble spawner slice.
package bubble_pkg;

  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_SIZE_W    = 3;
  localparam int DEF_COORD_W   = 11;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CHILD_A,
    CHILD_B,
    LEVEL
  } spawner_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bubble_spawner_if.sv
// Signal bundle between the controller / bubble bank (master) and the
// spawner (slave).
interface bubble_spawner_if #(
  parameter int NUM_SLOTS = bubble_pkg::DEF_NUM_SLOTS,
  parameter int SIZE_W    = bubble_pkg::DEF_SIZE_W,
  parameter int COORD_W   = bubble_pkg::DEF_COORD_W
);

  logic                           levelStart;
  logic [SIZE_W-1:0]              initSize;
  logic [COORD_W-1:0]             initX;
  logic [COORD_W-1:0]             initY;
  logic [NUM_SLOTS-1:0]           split;
  logic [NUM_SLOTS*COORD_W-1:0]   parentX;
  logic [NUM_SLOTS*COORD_W-1:0]   parentY;
  logic [NUM_SLOTS*SIZE_W-1:0]    parentSize;

  logic [NUM_SLOTS-1:0]           start;
  logic [NUM_SLOTS*SIZE_W-1:0]    size;
  logic [NUM_SLOTS-1:0]           direction;
  logic [NUM_SLOTS*COORD_W-1:0]   startTopX;
  logic [NUM_SLOTS*COORD_W-1:0]   startTopY;
  logic [NUM_SLOTS-1:0]           active;
  logic                           allCleared;
  logic                           overflow;

  modport master (
    output levelStart, initSize, initX, initY, split, parentX, parentY, parentSize,
    input  start, size, direction, startTopX, startTopY, active, allCleared, overflow
  );

  modport slave (
    input  levelStart, initSize, initX, initY, split, parentX, parentY, parentSize,
    output start, size, direction, startTopX, startTopY, active, allCleared, overflow
  );

endinterface

// File: rtl/slot_priority_enc.sv
// Lowest-set-bit encoder: returns the smallest index with vec[idx]=1 and a
// valid flag when any bit is set.
module slot_priority_enc #(
  parameter int N = bubble_pkg::DEF_NUM_SLOTS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bubble_spawner.sv
// Slot manager for the bubble bank: launches the initial bubble on levelStart
// and turns each split into two children placed in the lowest free slots.
module bubble_spawner #(
  parameter int NUM_SLOTS = bubble_pkg::DEF_NUM_SLOTS,
  parameter int SIZE_W    = bubble_pkg::DEF_SIZE_W,
  parameter int COORD_W   = bubble_pkg::DEF_COORD_W
) (
  input logic             clk,
  input logic             reset,
  bubble_spawner_if.slave bus
);

  import bubble_pkg::*;

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  spawner_state_t state, next_state;

  logic [NUM_SLOTS-1:0] pend;
  logic [NUM_SLOTS-1:0] active_q;
  logic [NUM_SLOTS-1:0] start_q;
  logic [NUM_SLOTS-1:0] dir_q;
  logic                 overflow_q;
  logic                 all_cleared_q;

  logic [SIZE_W-1:0]  size_r [NUM_SLOTS];
  logic [COORD_W-1:0] x_r    [NUM_SLOTS];
  logic [COORD_W-1:0] y_r    [NUM_SLOTS];

  logic [SIZE_W-1:0]  par_s  [NUM_SLOTS];
  logic [COORD_W-1:0] par_x  [NUM_SLOTS];
  logic [COORD_W-1:0] par_y  [NUM_SLOTS];

  logic [SIZE_W-1:0]  cap_s  [NUM_SLOTS];
  logic [COORD_W-1:0] cap_x  [NUM_SLOTS];
  logic [COORD_W-1:0] cap_y  [NUM_SLOTS];

  logic [SIZE_W-1:0]  work_s;
  logic [COORD_W-1:0] work_x;
  logic [COORD_W-1:0] work_y;

  logic [IDX_W-1:0]     pend_idx, free_idx;
  logic                 pend_valid, free_valid;
  logic [NUM_SLOTS-1:0] capture;

  logic take_pend, launch_child, launch_level, launch_dir;

  // Only splits from occupied slots are real; stale pulses are dropped.
  assign capture = bus.split & active_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot_io
    assign par_s[g] = bus.parentSize[g*SIZE_W +: SIZE_W];
    assign par_x[g] = bus.parentX[g*COORD_W +: COORD_W];
    assign par_y[g] = bus.parentY[g*COORD_W +: COORD_W];
    assign bus.size[g*SIZE_W +: SIZE_W]       = size_r[g];
    assign bus.startTopX[g*COORD_W +: COORD_W] = x_r[g];
    assign bus.startTopY[g*COORD_W +: COORD_W] = y_r[g];
  end

  assign bus.start      = start_q;
  assign bus.direction  = dir_q;
  assign bus.active     = active_q;
  assign bus.overflow   = overflow_q;
  assign bus.allCleared = all_cleared_q;

  slot_priority_enc #(.N(NUM_SLOTS)) u_pend_enc (
    .vec   (pend),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  slot_priority_enc #(.N(NUM_SLOTS)) u_free_enc (
    .vec   (~active_q),
    .idx   (free_idx),
    .valid (free_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    take_pend    = 1'b0;
    launch_child = 1'b0;
    launch_level = 1'b0;
    launch_dir   = DIR_LEFT;
    if (bus.levelStart) begin
      next_state = LEVEL;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend_valid) begin
            take_pend  = 1'b1;
            next_state = SELECT;
          end
        end
        SELECT:  next_state = (work_s == '0) ? IDLE : CHILD_A;
        CHILD_A: begin
          launch_child = 1'b1;
          launch_dir   = DIR_LEFT;
          next_state   = CHILD_B;
        end
        CHILD_B: begin
          launch_child = 1'b1;
          launch_dir   = DIR_RIGHT;
          next_state   = IDLE;
        end
        LEVEL: begin
          launch_level = 1'b1;
          next_state   = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend          <= '0;
      active_q      <= '0;
      start_q       <= '0;
      dir_q         <= '0;
      overflow_q    <= 1'b0;
      all_cleared_q <= 1'b1;
      size_r        <= '{default: '0};
      x_r           <= '{default: '0};
      y_r           <= '{default: '0};
    end else begin
      start_q       <= '0;
      all_cleared_q <= (active_q == '0) && (pend == '0) && (state == IDLE);
      if (bus.levelStart) begin
        pend       <= '0;
        active_q   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (take_pend) pend[pend_idx] <= 1'b0;
        // A fresh capture on the slot being dequeued wins over the clear.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (capture[i]) begin
            pend[i]     <= 1'b1;
            active_q[i] <= 1'b0;
          end
        end
        if (launch_child) begin
          if (free_valid) begin
            size_r[free_idx]   <= work_s - SIZE_W'(1);
            dir_q[free_idx]    <= launch_dir;
            x_r[free_idx]      <= work_x;
            y_r[free_idx]      <= work_y;
            start_q[free_idx]  <= 1'b1;
            active_q[free_idx] <= 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end
        if (launch_level) begin
          size_r[0]   <= bus.initSize;
          dir_q[0]    <= DIR_RIGHT;
          x_r[0]      <= bus.initX;
          y_r[0]      <= bus.initY;
          start_q[0]  <= 1'b1;
          active_q[0] <= 1'b1;
        end
      end
    end
  end

  // NOTE: capture and work registers need no reset; they are only read after pend marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (capture[i]) begin
        cap_s[i] <= par_s[i];
        cap_x[i] <= par_x[i];
        cap_y[i] <= par_y[i];
      end
    end
    if (take_pend) begin
      work_s <= cap_s[pend_idx];
      work_x <= cap_x[pend_idx];
      work_y <= cap_y[pend_idx];
    end
  end

endmodule

// File: tb/tb_bubble_spawner.sv
// Self-checking bench for bubble_spawner: directed scenarios followed by
// randomized split traffic compared against a slot-occupancy model.
module tb_bubble_spawner;

  import bubble_pkg::*;

  localparam int N  = DEF_NUM_SLOTS;
  localparam int SW = DEF_SIZE_W;
  localparam int CW = DEF_COORD_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bubble_spawner_if #(.NUM_SLOTS(N), .SIZE_W(SW), .COORD_W(CW)) bus ();

  bubble_spawner #(.NUM_SLOTS(N), .SIZE_W(SW), .COORD_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what each slot should currently hold.
  bit m_active [N];
  int m_size   [N];
  int m_dir    [N];
  int m_x      [N];
  int m_y      [N];
  bit m_ovf;
  int m_launch = 0;
  int exp_a, exp_b;

  // Values the bubble bank presents on parentX/Y/Size.
  int par_s [N];
  int par_x [N];
  int par_y [N];

  // Start-pulse monitor.
  logic [N-1:0] prev_start = '0;
  int pulse_cnt = 0;
  int dbl_cnt   = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_start = '0;
    end else begin
      if ((bus.start & prev_start) != '0) dbl_cnt++;
      pulse_cnt += $countones(bus.start);
      prev_start = bus.start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_parents();
    for (int i = 0; i < N; i++) begin
      bus.parentSize[i*SW +: SW] = SW'(par_s[i]);
      bus.parentX[i*CW +: CW]    = CW'(par_x[i]);
      bus.parentY[i*CW +: CW]    = CW'(par_y[i]);
    end
  endtask

  task automatic set_par(int i, int s, int x, int y);
    par_s[i] = s;
    par_x[i] = x;
    par_y[i] = y;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0; m_size[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_ovf = 0;
  endtask

  task automatic model_level(int s, int x, int y);
    for (int i = 0; i < N; i++) m_active[i] = 0;
    m_ovf = 0;
    m_active[0] = 1; m_size[0] = s; m_dir[0] = 1; m_x[0] = x; m_y[0] = y;
    m_launch++;
  endtask

  // All split parents free their slots at once, then are served lowest index
  // first, each placing a left child then a right child in the lowest free slot.
  task automatic model_split(logic [N-1:0] mask);
    bit cap [N];
    bit first = 1;
    int f;
    exp_a = -1;
    exp_b = -1;
    for (int i = 0; i < N; i++) begin
      cap[i] = mask[i] && m_active[i];
      if (cap[i]) m_active[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (cap[i]) begin
        if (par_s[i] != 0) begin
          for (int d = 0; d < 2; d++) begin
            f = -1;
            for (int k = N - 1; k >= 0; k--) if (!m_active[k]) f = k;
            if (f >= 0) begin
              m_active[f] = 1; m_size[f] = par_s[i] - 1; m_dir[f] = d;
              m_x[f] = par_x[i]; m_y[f] = par_y[i];
              m_launch++;
            end else begin
              m_ovf = 1;
            end
            if (first) begin
              if (d == 0) exp_a = f;
              else        exp_b = f;
            end
          end
        end
        first = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] onehot(int f);
    logic [N-1:0] v;
    v = '0;
    if (f >= 0) v[f] = 1'b1;
    return v;
  endfunction

  task automatic compare_all(string tag);
    logic [N-1:0] exp_act;
    exp_act = '0;
    for (int i = 0; i < N; i++) exp_act[i] = m_active[i];
    check({tag, ":active"},     32'(bus.active),     32'(exp_act));
    check({tag, ":overflow"},   32'(bus.overflow),   32'(m_ovf));
    check({tag, ":allCleared"}, 32'(bus.allCleared), 32'(exp_act == '0));
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s:size[%0d]", tag, i), 32'(bus.size[i*SW +: SW]), m_size[i]);
      check($sformatf("%s:dir[%0d]", tag, i),  32'(bus.direction[i]),     m_dir[i]);
      check($sformatf("%s:x[%0d]", tag, i),    32'(bus.startTopX[i*CW +: CW]), m_x[i]);
      check($sformatf("%s:y[%0d]", tag, i),    32'(bus.startTopY[i*CW +: CW]), m_y[i]);
    end
  endtask

  task automatic do_level(int s, int x, int y);
    bus.initSize   = SW'(s);
    bus.initX      = CW'(x);
    bus.initY      = CW'(y);
    bus.levelStart = 1'b1;
    tick();
    bus.levelStart = 1'b0;
    model_level(s, x, y);
    tick();
    check("level_start_t+2", 32'(bus.start), 32'(onehot(0)));
    tick();
    check("level_start_one_cycle", 32'(bus.start), 32'(0));
    repeat (2) tick();
  endtask

  task automatic do_split(logic [N-1:0] mask, bit timed);
    drive_parents();
    bus.split = mask;
    model_split(mask);
    tick();
    bus.split = '0;
    if (timed) begin
      repeat (3) tick();
      check("childA_start_t+4", 32'(bus.start), 32'(onehot(exp_a)));
      tick();
      check("childB_start_t+5", 32'(bus.start), 32'(onehot(exp_b)));
    end
    repeat (5 * $countones(mask) + 6) tick();
  endtask

  task automatic split_one(int i, bit timed);
    set_par(i, m_size[i], $urandom_range(0, 2047), $urandom_range(0, 2047));
    do_split(onehot(i), timed);
  endtask

  // Split two size-1 slots, then stop in the CHILD_A cycle (t+3) with pend still set.
  task automatic split_to_child_a();
    set_par(0, 1, 11, 22);
    set_par(1, 1, 33, 44);
    drive_parents();
    bus.split = onehot(0) | onehot(1);
    tick();
    bus.split = '0;
    repeat (2) tick();
  endtask

  initial begin
    int snap;
    logic [N-1:0] mask, act;
    reset          = 1'b1;
    bus.levelStart = 1'b0;
    bus.split      = '0;
    bus.initSize   = '0;
    bus.initX      = '0;
    bus.initY      = '0;
    drive_parents();
    repeat (3) tick();
    compare_all("reset");
    check("reset_start", 32'(bus.start), 32'(0));
    reset = 1'b0;
    tick();

    // Level start and basic split.
    do_level(3, 100, 50);
    compare_all("level");
    set_par(0, 3, 200, 80);
    do_split(onehot(0), 1'b1);
    compare_all("basic_split");

    // Terminal pop.
    do_level(0, 7, 9);
    set_par(0, 0, 5, 5);
    do_split(onehot(0), 1'b1);
    compare_all("terminal_pop");

    // Simultaneous splits.
    do_level(2, 400, 300);
    set_par(0, 2, 410, 310);
    do_split(onehot(0), 1'b0);
    set_par(0, 1, 500, 120);
    set_par(1, 1, 600, 220);
    do_split(onehot(0) | onehot(1), 1'b1);
    compare_all("simultaneous");

    // Overflow: fill all slots, then split slot 7.
    do_level(4, 1000, 20);
    split_one(0, 1'b0);
    split_one(0, 1'b0);
    split_one(1, 1'b0);
    split_one(0, 1'b0);
    split_one(1, 1'b0);
    split_one(2, 1'b0);
    split_one(3, 1'b0);
    compare_all("filled");
    set_par(7, 2, 1234, 567);
    do_split(onehot(7), 1'b1);
    compare_all("overflow");
    repeat (5) tick();
    check("overflow_sticky", 32'(bus.overflow), 32'(1));
    do_level(1, 60, 70);
    compare_all("overflow_cleared");

    // Reset during CHILD_A with pending work.
    do_level(2, 10, 10);
    split_one(0, 1'b0);
    split_to_child_a();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    snap = pulse_cnt;
    check("reset_abort_start", 32'(bus.start), 32'(0));
    compare_all("reset_abort");
    repeat (12) tick();
    check("reset_abort_no_launch", pulse_cnt - snap, 0);
    compare_all("reset_abort_settled");

    // levelStart during CHILD_A with pending work.
    do_level(2, 10, 10);
    split_one(0, 1'b0);
    split_to_child_a();
    snap = pulse_cnt;
    bus.initSize   = SW'(1);
    bus.initX      = CW'(300);
    bus.initY      = CW'(400);
    bus.levelStart = 1'b1;
    tick();
    bus.levelStart = 1'b0;
    check("level_abort_no_child", 32'(bus.start), 32'(0));
    tick();
    check("level_abort_slot0", 32'(bus.start), 32'(onehot(0)));
    model_level(1, 300, 400);
    repeat (12) tick();
    check("level_abort_one_launch", pulse_cnt - snap, 1);
    compare_all("level_abort");

    // Randomized split traffic.
    for (int it = 0; it < 30; it++) begin
      act = '0;
      for (int i = 0; i < N; i++) act[i] = m_active[i];
      if (act == '0 || $urandom_range(0, 9) == 0) begin
        do_level($urandom_range(0, 4), $urandom_range(0, 2047), $urandom_range(0, 2047));
      end else begin
        mask = N'($urandom);
        if ((mask & act) == '0) begin
          for (int i = 0; i < N; i++) if (act[i] && (mask & act) == '0) mask[i] = 1'b1;
        end
        for (int i = 0; i < N; i++)
          set_par(i, m_active[i] ? m_size[i] : $urandom_range(0, 7),
                  $urandom_range(0, 2047), $urandom_range(0, 2047));
        do_split(mask, 1'b0);
      end
      compare_all($sformatf("rand%0d", it));
    end

    check("start_pulse_count", pulse_cnt, m_launch);
    check("start_double_pulse", dbl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
